// File: rtl/sqrt_floor_seq.sv
// Bit-serial floor(sqrt(n)) controller around the shared 5-bit combinational squarer.
// Optional SQRT_REM_EN adds the out_rem port (n - root^2) and a square-tracking register.

module squarer_5 (
    input  logic [4:0] a,
    output logic [9:0] sq
);
    assign sq = {5'd0, a} * {5'd0, a};
endmodule

module sqrt_floor_seq #(
    parameter int ROOT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*ROOT_W-1:0]   in_n,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ROOT_W-1:0]     out_root
`ifdef SQRT_REM_EN
    ,
    output logic [ROOT_W:0]       out_rem
`endif
);

    localparam int N_W = 2 * ROOT_W;
    localparam int K_W = $clog2(ROOT_W);

    if (ROOT_W != 5) begin : g_width_check
        $error("sqrt_floor_seq: ROOT_W must be 5 to match squarer_5");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [ROOT_W-1:0]   acc_q, acc_d;
    logic [N_W-1:0]      n_q, n_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [ROOT_W-1:0]   out_root_q, out_root_d;
`ifdef SQRT_REM_EN
    logic [N_W-1:0]      sq_acc_q, sq_acc_d;
    logic [ROOT_W:0]     out_rem_q, out_rem_d;
`endif

    logic [ROOT_W-1:0]   trial;
    logic [ROOT_W-1:0]   sq_in;
    logic [N_W-1:0]      sq;
    logic                keep;

    assign trial = acc_q | (ROOT_W'(1) << k_q);
    // Gate the squarer input so the datapath stays quiet outside CALC.
    assign sq_in = (state_q == CALC) ? trial : '0;
    assign keep  = (sq <= n_q);

    squarer_5 u_squarer (
        .a  (sq_in),
        .sq (sq)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        n_d         = n_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_root_d  = out_root_q;
`ifdef SQRT_REM_EN
        sq_acc_d    = sq_acc_q;
        out_rem_d   = out_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d        = in_n;
                    acc_d      = '0;
                    k_d        = K_W'(ROOT_W - 1);
                    in_ready_d = 1'b0;
                    state_d    = CALC;
`ifdef SQRT_REM_EN
                    sq_acc_d   = '0;
`endif
                end
            end
            CALC: begin
                if (keep) begin
                    acc_d = trial;
`ifdef SQRT_REM_EN
                    sq_acc_d = sq;
`endif
                end
                if (k_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_root_d  = keep ? trial : acc_q;
`ifdef SQRT_REM_EN
                    out_rem_d   = (ROOT_W + 1)'(n_q - (keep ? sq : sq_acc_q));
`endif
                end else begin
                    k_d = K_W'(k_q - 1'b1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= K_W'(ROOT_W - 1);
            acc_q       <= '0;
            n_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_root_q  <= '0;
`ifdef SQRT_REM_EN
            sq_acc_q    <= '0;
            out_rem_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            n_q         <= n_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_root_q  <= out_root_d;
`ifdef SQRT_REM_EN
            sq_acc_q    <= sq_acc_d;
            out_rem_q   <= out_rem_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_root  = out_root_q;
`ifdef SQRT_REM_EN
    assign out_rem   = out_rem_q;
`endif

endmodule

// File: tb/tb_sqrt_floor_seq.sv
// Directed and exhaustive checks of sqrt_floor_seq: latency, handshakes, backpressure, async reset.
// Remainder checks are compiled in only when SQRT_REM_EN is defined.

module tb_sqrt_floor_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_n = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [4:0] out_root;
`ifdef SQRT_REM_EN
    logic [5:0] out_rem;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sqrt_floor_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_n      (in_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_root  (out_root)
`ifdef SQRT_REM_EN
        ,
        .out_rem   (out_rem)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_root(input int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // Present n and wait (bounded) for the accept edge; returns just after it.
    task automatic accept(input int n);
        int waited = 0;
        in_valid = 1'b1;
        in_n     = 10'(n);
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("accept_timeout", int'(waited >= 20), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_n     = ~10'(n);
    endtask

    // Called just after the accept edge T: result must appear at T+5.
    task automatic expect_result(input string tag, input int exp_root, input int exp_rem);
        for (int i = 1; i <= 5; i++) begin
            check({tag, "_in_ready_busy"}, int'(in_ready), 0);
            @(posedge clk); #1;
            check({tag, "_out_valid_lat"}, int'(out_valid), int'(i == 5));
        end
        check({tag, "_in_ready_done"}, int'(in_ready), 0);
        check({tag, "_root"}, int'(out_root), exp_root);
`ifdef SQRT_REM_EN
        check({tag, "_rem"}, int'(out_rem), exp_rem);
`else
        if (exp_rem < 0) $display("unexpected negative remainder in %s", tag);
`endif
    endtask

    // With out_ready high, DONE must drop to IDLE on the next edge.
    task automatic finish_op(input string tag);
        @(posedge clk); #1;
        check({tag, "_out_valid_drop"}, int'(out_valid), 0);
        check({tag, "_in_ready_back"}, int'(in_ready), 1);
    endtask

    task automatic run_op(input string tag, input int n, input int exp_root, input int exp_rem);
        accept(n);
        expect_result(tag, exp_root, exp_rem);
        finish_op(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #13;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_root", int'(out_root), 0);
`ifdef SQRT_REM_EN
        check("rst_out_rem", int'(out_rem), 0);
`endif
        #10 rst_n = 1'b1;

        // First edge after reset release accepts n=0.
        run_op("n0", 0, 0, 0);
        run_op("n1023", 1023, 31, 62);
        run_op("n961", 961, 31, 0);
        run_op("n100", 100, 10, 0);
        run_op("n99", 99, 9, 18);
        run_op("n1", 1, 1, 0);
        run_op("n3", 3, 1, 2);

        // Backpressure: result held for 10 cycles, pending n=50 must wait.
        out_ready = 1'b0;
        accept(200);
        expect_result("bp", 14, 4);
        in_valid = 1'b1;
        in_n     = 10'd50;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_root", int'(out_root), 14);
`ifdef SQRT_REM_EN
            check("bp_hold_rem", int'(out_rem), 4);
`endif
            check("bp_no_accept", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_n     = 10'd0;
        expect_result("bp_n50", 7, 1);
        finish_op("bp_n50");

        // Exhaustive back-to-back stream; in_ready at T+6 makes each accept land at T+7.
        for (int n = 0; n < 1024; n++) begin
            int r;
            r = ref_root(n);
            run_op($sformatf("ex%0d", n), n, r, n - r * r);
        end

        // Asynchronous reset during the 3rd CALC cycle.
        accept(500);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", int'(in_ready), 1);
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_out_root", int'(out_root), 0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("arst_no_result", int'(out_valid), 0);
            check("arst_idle_ready", int'(in_ready), 1);
        end
        run_op("arst_n625", 625, 25, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
